ds_operand_stage: RTL and testbench

Parametrised decode-stage pipeline register plus operand forwarding/interlock unit for the five-stage MIPS core. It sits between fetch and execute: latches fetch's instruction/PC under valid/allowin handshake, resolves rs/rt operand values from N producer stages or the register file, and holds the instruction while any needed producer result is not yet available. It also supports a flush and counts interlock cycles.

---
 rtl/ds_operand_stage.sv | 136 +++++++++++++
 tb/tb_ds_operand_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_operand_stage.sv
// ds_operand_stage: decode-stage pipeline register with rs/rt operand forwarding and load-use interlock.
// Optional feature macro: DS_BYPASS_EN. When it is defined, results are forwarded from the producer stages.
// When it is undefined, operands always come from the register file, and any younger matching producer stalls the stage.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   fs_to_ds_valid, fs_inst/pc fetch handshake and payload; ds_allowin goes back to fetch
//   es_allowin, ds_to_es_valid execute handshake; flush drops the held instruction
//   ds_inst, ds_pc             held instruction and PC
//   rs_used, rt_used           decoder source-use flags
//   rf_raddr1/2, rf_rdata1/2   register file read port
//   fwd_valid/dest/ready/data  producer stages, index 0 youngest (EX) .. NFWD-1 oldest (WB)
//   rs_value, rt_value         resolved operands
//   stall_cnt                  saturating count of interlock cycles
module ds_operand_stage #(
    parameter int XLEN  = 32,
    parameter int NFWD  = 3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [31:0]            fs_inst,
    input  logic [XLEN-1:0]        fs_pc,
    output logic                   ds_allowin,
    input  logic                   es_allowin,
    output logic                   ds_to_es_valid,
    input  logic                   flush,
    output logic [31:0]            ds_inst,
    output logic [XLEN-1:0]        ds_pc,
    input  logic                   rs_used,
    input  logic                   rt_used,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [5*NFWD-1:0]      fwd_dest,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic [XLEN*NFWD-1:0]   fwd_data,
    output logic [XLEN-1:0]        rs_value,
    output logic [XLEN-1:0]        rt_value,
    output logic [CNT_W-1:0]       stall_cnt
);
    logic                ds_valid_q, ds_valid_d;
    logic [31:0]         ds_inst_q, ds_inst_d;
    logic [XLEN-1:0]     ds_pc_q, ds_pc_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                ds_ready_go, rs_blocked, rt_blocked, load;
    logic [NFWD-1:0]     rs_match, rt_match;

    // Register 0 and unused sources never match a producer.
    function automatic logic [NFWD-1:0] match_vec(input logic [4:0] addr, input logic used,
                                                  input logic [NFWD-1:0] v, input logic [5*NFWD-1:0] dest);
        logic [NFWD-1:0] m;
        for (int i = 0; i < NFWD; i++)
            m[i] = used && (addr != 5'd0) && v[i] && (dest[5*i +: 5] == addr);
        return m;
    endfunction

    assign rf_raddr1 = ds_inst_q[25:21];
    assign rf_raddr2 = ds_inst_q[20:16];
    assign rs_match  = match_vec(rf_raddr1, rs_used, fwd_valid, fwd_dest);
    assign rt_match  = match_vec(rf_raddr2, rt_used, fwd_valid, fwd_dest);

`ifdef DS_BYPASS_EN
    logic [NFWD-1:0] rs_sel, rt_sel;

    // The youngest match holds the architecturally newest value, so older matches are ignored.
    function automatic logic [NFWD-1:0] lowest(input logic [NFWD-1:0] m);
        logic [NFWD-1:0] oh;
        oh = '0;
        for (int i = NFWD - 1; i >= 0; i--)
            if (m[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        return oh;
    endfunction

    function automatic logic [XLEN-1:0] pick(input logic [NFWD-1:0] oh, input logic [XLEN*NFWD-1:0] data,
                                             input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] r;
        r = rf;
        for (int i = 0; i < NFWD; i++)
            if (oh[i]) r = data[XLEN*i +: XLEN];
        return r;
    endfunction

    assign rs_sel     = lowest(rs_match);
    assign rt_sel     = lowest(rt_match);
    assign rs_blocked = |(rs_sel & ~fwd_ready);
    assign rt_blocked = |(rt_sel & ~fwd_ready);
    assign rs_value   = pick(rs_sel, fwd_data, rf_rdata1);
    assign rt_value   = pick(rt_sel, fwd_data, rf_rdata2);
`else
    // WB (index NFWD-1) writes the register file in the same cycle it is read, so only younger producers stall.
    localparam logic [NFWD-1:0] YOUNG = {NFWD{1'b1}} >> 1;
    logic unused_fwd;

    assign rs_blocked = |(rs_match & YOUNG);
    assign rt_blocked = |(rt_match & YOUNG);
    assign rs_value   = rf_rdata1;
    assign rt_value   = rf_rdata2;
    assign unused_fwd = ^{fwd_ready, fwd_data};
`endif

    assign ds_ready_go    = ~(rs_blocked | rt_blocked);
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~flush;
    assign ds_inst        = ds_inst_q;
    assign ds_pc          = ds_pc_q;
    assign stall_cnt      = stall_cnt_q;

    // Flush wins over a simultaneous accept: nothing is latched and the stage empties.
    always_comb begin
        load        = fs_to_ds_valid & ds_allowin & ~flush;
        ds_valid_d  = flush ? 1'b0 : (ds_allowin ? fs_to_ds_valid : ds_valid_q);
        ds_inst_d   = load ? fs_inst : ds_inst_q;
        ds_pc_d     = load ? fs_pc : ds_pc_q;
        stall_cnt_d = (ds_valid_q & ~ds_ready_go & ~flush & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q  <= 1'b0;
            ds_inst_q   <= '0;
            ds_pc_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            ds_inst_q   <= ds_inst_d;
            ds_pc_q     <= ds_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_ds_operand_stage.sv
// tb_ds_operand_stage: table-driven and sequence checks of the decode operand stage (NFWD=3, CNT_W=2).
module tb_ds_operand_stage;
    localparam int XLEN  = 32;
    localparam int NFWD  = 3;
    localparam int CNT_W = 2;
`ifdef DS_BYPASS_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif
    localparam logic [31:0] RF1   = 32'hAAAA_0001;
    localparam logic [31:0] RF2   = 32'hBBBB_0002;
    localparam logic [95:0] FDATA = {32'h33, 32'h22, 32'h11};

    logic                 clk = 1'b0;
    logic                 reset, fs_to_ds_valid, es_allowin, flush, rs_used, rt_used;
    logic [31:0]          fs_inst, ds_inst;
    logic [XLEN-1:0]      fs_pc, ds_pc, rf_rdata1, rf_rdata2, rs_value, rt_value;
    logic                 ds_allowin, ds_to_es_valid;
    logic [4:0]           rf_raddr1, rf_raddr2;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [5*NFWD-1:0]    fwd_dest;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic [CNT_W-1:0]     stall_cnt;

    int total = 0;
    int passed = 0;

    ds_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .flush(flush),
        .ds_inst(ds_inst), .ds_pc(ds_pc), .rs_used(rs_used), .rt_used(rt_used),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .rs_value(rs_value), .rt_value(rt_value), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        rs_u, rt_u;
        logic [2:0]  fv;
        logic [14:0] fd;
        logic [2:0]  fr;
        logic [31:0] ers, ert;
        logic        ego;
    } vec_t;

    vec_t tv[9];

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 5'd0, 5'd0, 6'h21};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        fs_to_ds_valid = 1'b0;
        flush = 1'b0;
        es_allowin = 1'b1;
        fwd_valid = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic block_on_8(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1'b1;
        fs_inst = inst;
        fs_pc = pc;
        rs_used = 1'b1;
        rt_used = 1'b1;
        fwd_valid = 3'b001;
        fwd_dest = {5'd0, 5'd0, 5'd8};
        fwd_ready = 3'b000;
        es_allowin = 1'b1;
        tick;
        fs_to_ds_valid = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        fs_inst = '0; fs_pc = '0; rs_used = 1'b0; rt_used = 1'b0;
        fwd_dest = '0; fwd_ready = '0; fwd_data = FDATA;
        rf_rdata1 = RF1; rf_rdata2 = RF2;

        tv[0] = '{5'd1,  5'd2,  1'b1, 1'b1, 3'b000, {5'd0, 5'd0, 5'd0},   3'b000, RF1, RF2, 1'b1};
        tv[1] = '{5'd5,  5'd6,  1'b1, 1'b1, 3'b011, {5'd0, 5'd5, 5'd5},   3'b011, BP ? 32'h11 : RF1, RF2, BP};
        tv[2] = '{5'd7,  5'd8,  1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd8},   3'b000, RF1, RF2, 1'b1};
        tv[3] = '{5'd0,  5'd0,  1'b1, 1'b1, 3'b111, {5'd0, 5'd0, 5'd0},   3'b000, RF1, RF2, 1'b1};
        tv[4] = '{5'd9,  5'd4,  1'b1, 1'b1, 3'b100, {5'd4, 5'd0, 5'd0},   3'b000, RF1, BP ? 32'h33 : RF2, ~BP};
        tv[5] = '{5'd9,  5'd10, 1'b1, 1'b1, 3'b110, {5'd9, 5'd9, 5'd0},   3'b110, BP ? 32'h22 : RF1, RF2, BP};
        tv[6] = '{5'd3,  5'd3,  1'b1, 1'b1, 3'b001, {5'd0, 5'd0, 5'd3},   3'b001, BP ? 32'h11 : RF1, BP ? 32'h11 : RF2, BP};
        tv[7] = '{5'd12, 5'd13, 1'b1, 1'b1, 3'b011, {5'd0, 5'd12, 5'd12}, 3'b010, BP ? 32'h11 : RF1, RF2, 1'b0};
        tv[8] = '{5'd5,  5'd6,  1'b0, 1'b1, 3'b001, {5'd0, 5'd0, 5'd5},   3'b000, RF1, RF2, 1'b1};

        do_reset;
        chkb("rst_to_es", ds_to_es_valid, 1'b0);
        chkb("rst_allowin", ds_allowin, 1'b1);
        chk("rst_inst", ds_inst, 32'h0);
        chk("rst_pc", ds_pc, 32'h0);
        chk("rst_cnt", {30'd0, stall_cnt}, 32'd0);

        rs_used = 1'b1;
        rt_used = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fs_to_ds_valid = 1'b1;
            fs_inst = mk(5'(k + 1), 5'(k + 2));
            fs_pc = 32'h1000 + 32'(4 * k);
            tick;
            chk($sformatf("st%0d_inst", k), ds_inst, mk(5'(k + 1), 5'(k + 2)));
            chk($sformatf("st%0d_pc", k), ds_pc, 32'h1000 + 32'(4 * k));
            chkb($sformatf("st%0d_to_es", k), ds_to_es_valid, 1'b1);
            chkb($sformatf("st%0d_allowin", k), ds_allowin, 1'b1);
        end
        fs_to_ds_valid = 1'b0;
        tick;
        chkb("st_empty", ds_to_es_valid, 1'b0);
        chk("st_cnt", {30'd0, stall_cnt}, 32'd0);

        do_reset;
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            fs_to_ds_valid = 1'b1;
            fs_inst = mk(tv[i].rs, tv[i].rt);
            fs_pc = 32'h2000 + 32'(4 * i);
            es_allowin = 1'b1;
            fwd_valid = '0;
            tick;
            fs_to_ds_valid = 1'b0;
            es_allowin = 1'b0;
            rs_used = tv[i].rs_u;
            rt_used = tv[i].rt_u;
            fwd_valid = tv[i].fv;
            fwd_dest = tv[i].fd;
            fwd_ready = tv[i].fr;
            #1;
            chk($sformatf("v%0d_rs", i), rs_value, tv[i].ers);
            chk($sformatf("v%0d_rt", i), rt_value, tv[i].ert);
            chkb($sformatf("v%0d_go", i), ds_to_es_valid, tv[i].ego);
            chk($sformatf("v%0d_raddr", i), {22'd0, rf_raddr1, rf_raddr2}, {22'd0, tv[i].rs, tv[i].rt});
            tick;
            if (!tv[i].ego && exp_cnt != 3) exp_cnt++;
            chkb($sformatf("v%0d_hold", i), ds_to_es_valid, tv[i].ego);
            chk($sformatf("v%0d_cnt", i), {30'd0, stall_cnt}, 32'(exp_cnt));
            fwd_valid = '0;
            es_allowin = 1'b1;
            tick;
        end

        do_reset;
        fwd_data = {32'h0, 32'h0, 32'h0};
        block_on_8(mk(5'd1, 5'd8), 32'h2800);
        #1;
        chkb("lu_go0", ds_to_es_valid, 1'b0);
        chkb("lu_allowin0", ds_allowin, 1'b0);
        tick;
        chk("lu_cnt1", {30'd0, stall_cnt}, 32'd1);
        fwd_valid = 3'b010;
        fwd_dest = {5'd0, 5'd8, 5'd0};
        fwd_ready = 3'b010;
        fwd_data = {32'h0, 32'hDA, 32'h0};
        #1;
`ifdef DS_BYPASS_EN
        chkb("lu_go1", ds_to_es_valid, 1'b1);
        chk("lu_rt", rt_value, 32'hDA);
        tick;
`else
        chkb("lu_go1", ds_to_es_valid, 1'b0);
        tick;
        chk("lu_cnt2", {30'd0, stall_cnt}, 32'd2);
        fwd_valid = 3'b100;
        fwd_dest = {5'd8, 5'd0, 5'd0};
        fwd_ready = 3'b100;
        #1;
        chkb("lu_go2", ds_to_es_valid, 1'b1);
        chk("lu_rt", rt_value, RF2);
        tick;
`endif
        fwd_valid = '0;
        #1;
        chkb("lu_drained", ds_to_es_valid, 1'b0);
        chk("lu_cnt_end", {30'd0, stall_cnt}, BP ? 32'd1 : 32'd2);

        do_reset;
        block_on_8(mk(5'd2, 5'd8), 32'h3000);
        #1;
        chkb("fl_blk", ds_to_es_valid, 1'b0);
        tick;
        chk("fl_cnt1", {30'd0, stall_cnt}, 32'd1);
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_inst = mk(5'd4, 5'd5);
        fs_pc = 32'h3004;
        #1;
        chkb("fl_to_es", ds_to_es_valid, 1'b0);
        tick;
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        fwd_valid = '0;
        #1;
        chkb("fl_after_to_es", ds_to_es_valid, 1'b0);
        chkb("fl_after_allowin", ds_allowin, 1'b1);
        chk("fl_after_inst", ds_inst, mk(5'd2, 5'd8));
        chk("fl_after_pc", ds_pc, 32'h3000);
        chk("fl_after_cnt", {30'd0, stall_cnt}, 32'd1);
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_inst = mk(5'd6, 5'd7);
        fs_pc = 32'h3008;
        tick;
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        chk("fl_accept_inst", ds_inst, mk(5'd2, 5'd8));
        chkb("fl_accept_to_es", ds_to_es_valid, 1'b0);
        fs_to_ds_valid = 1'b1;
        fs_inst = mk(5'd9, 5'd10);
        fs_pc = 32'h300C;
        tick;
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b0;
        #1;
        chkb("fl_ready_to_es", ds_to_es_valid, 1'b1);
        chk("fl_ready_inst", ds_inst, mk(5'd9, 5'd10));
        flush = 1'b1;
        #1;
        chkb("fl_gate", ds_to_es_valid, 1'b0);
        tick;
        flush = 1'b0;
        #1;
        chkb("fl_dropped", ds_to_es_valid, 1'b0);
        chkb("fl_dropped_allowin", ds_allowin, 1'b1);

        do_reset;
        block_on_8(mk(5'd1, 5'd8), 32'h4000);
        tick;
        chk("rm_cnt1", {30'd0, stall_cnt}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("rm_cnt", {30'd0, stall_cnt}, 32'd0);
        chkb("rm_to_es", ds_to_es_valid, 1'b0);
        chkb("rm_allowin", ds_allowin, 1'b1);
        chk("rm_inst", ds_inst, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
